// File: rtl/alu_bist_if.sv
// Bus between the ALU BIST controller and its environment (ALU plus run control).
// master: controller side. It drives the ALU operation/operands and the status outputs,
//         and receives control, the golden signature, the ALU result and the ALU flags.
// slave:  environment side (ALU model / sequencer), with the directions mirrored.
// alu_operation encoding (index into the fixed test order):
//   0 ADD, 1 SUB, 2 OR, 3 AND, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLTU, 9 SLT.
interface alu_bist_if #(
  parameter int unsigned BitCount = 32
);
  logic                start;
  logic                abort;
  logic [BitCount-1:0] expected_signature;
  logic [BitCount-1:0] alu_result;
  logic                zero;
  logic                overflow;
  logic                negative;
  logic                carry;
  logic [3:0]          alu_operation;
  logic [BitCount-1:0] alu_operand_a;
  logic [BitCount-1:0] alu_operand_b;
  logic                busy;
  logic                done;
  logic                pass;
  logic [BitCount-1:0] signature;

  modport master (
    input  start, abort, expected_signature, alu_result, zero, overflow, negative, carry,
    output alu_operation, alu_operand_a, alu_operand_b, busy, done, pass, signature
  );

  modport slave (
    output start, abort, expected_signature, alu_result, zero, overflow, negative, carry,
    input  alu_operation, alu_operand_a, alu_operand_b, busy, done, pass, signature
  );
endinterface

// File: rtl/alu_bist_controller.sv
// ALU built-in self-test initiator.
// It steps through ADD..SLT and applies Vectors LFSR-generated operand pairs to each operation.
// It compacts each ALU result and its flags into a MISR signature, and at the end compares the
// signature against the golden value.
// Ports:
//   clk_i   rising-edge clock
//   reset_i asynchronous active-high reset
//   bus     alu_bist_if.master: start/abort/expected_signature and the ALU result/flags in;
//           operation/operands, busy/done/pass and the signature out.
module alu_bist_controller #(
  parameter int unsigned         BitCount = 32,
  parameter int unsigned         Vectors  = 256,
  parameter logic [BitCount-1:0] SeedA    = BitCount'(1),
  parameter logic [BitCount-1:0] SeedB    = {(BitCount / 32){32'hA5A5_A5A5}},
  parameter logic [BitCount-1:0] Taps     = (BitCount == 64) ?
                                            BitCount'(64'hD800_0000_0000_0000) :
                                            BitCount'(32'h8020_0003)
) (
  input logic         clk_i,
  input logic         reset_i,
  alu_bist_if.master  bus
);

  localparam logic [3:0]  OpAdd   = 4'd0;
  localparam logic [3:0]  OpSlt   = 4'd9;
  localparam logic [15:0] LastVec = 16'(Vectors - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [BitCount-1:0] lfsr_q, lfsr_d;   // doubles as operand A
  logic [BitCount-1:0] opb_q, opb_d;
  logic [BitCount-1:0] sig_q, sig_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                pass_q, pass_d;

  logic [BitCount-1:0] lfsr_step, misr_in, misr_step;

  // Operand B: half-swapped LFSR value XORed with a fixed mask.
  function automatic logic [BitCount-1:0] mix_b(input logic [BitCount-1:0] l);
    return {l[BitCount/2-1:0], l[BitCount-1:BitCount/2]} ^ SeedB;
  endfunction

  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
    misr_in   = bus.alu_result ^
                {{(BitCount - 4){1'b0}}, bus.carry, bus.overflow, bus.negative, bus.zero};
    misr_step = ((sig_q >> 1) ^ (sig_q[0] ? Taps : '0)) ^ misr_in;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lfsr_d  = lfsr_q;
    opb_d   = opb_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          op_d    = OpAdd;
          lfsr_d  = SeedA;
          opb_d   = mix_b(SeedA);
          sig_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        // Abort leaves signature, operation and operands frozen where they were.
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          sig_d = misr_step;
          if (cnt_q == LastVec) begin
            cnt_d  = '0;
            lfsr_d = SeedA;
            opb_d  = mix_b(SeedA);
            if (op_q == OpSlt) begin
              state_d = StDone;
              pass_d  = (misr_step == bus.expected_signature);
            end else begin
              op_d = op_q + 4'd1;
            end
          end else begin
            cnt_d  = cnt_q + 16'd1;
            lfsr_d = lfsr_step;
            opb_d  = mix_b(lfsr_step);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      lfsr_q  <= '0;
      opb_q   <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lfsr_q  <= lfsr_d;
      opb_q   <= opb_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.alu_operation = op_q;
  assign bus.alu_operand_a = lfsr_q;
  assign bus.alu_operand_b = opb_q;
  assign bus.busy          = (state_q == StRun);
  assign bus.done          = (state_q == StDone);
  assign bus.pass          = pass_q;
  assign bus.signature     = sig_q;

endmodule
